// File: rtl/rgb_plane_writer_pkg.sv
// rgb_plane_writer_pkg: shared widths and FIFO entry layout for the planar RGB writer
package rgb_plane_writer_pkg;
  localparam int PIX_PER_WORD = 8;
  localparam int PLANE_WORD_W = 64;
  localparam int ADDR_W = 32;
  localparam int FIFO_ENTRY_W = 3 * PLANE_WORD_W + ADDR_W;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PLANE_WORD_W-1:0] b;
    logic [PLANE_WORD_W-1:0] g;
    logic [PLANE_WORD_W-1:0] r;
  } entry_t;
endpackage

// File: rtl/rgb_plane_writer_fifo.sv
// sync_fifo_sa: single-clock show-ahead FIFO; a push into a full FIFO is taken only alongside a pop
module sync_fifo_sa #(
  parameter int W = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign empty = cnt_q == '0;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign dout = mem_q[rd_ptr_q];
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/rgb_plane_writer.sv
// rgb_plane_writer: packs 8 RGB pixels into three planar 64-bit words and drains them over req/ack
module rgb_plane_writer
  import rgb_plane_writer_pkg::*;
#(
  parameter int width = 1920,
  parameter int height = 1080,
  parameter int fifoDepth = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iValid,
  input  logic [7:0]  iR,
  input  logic [7:0]  iG,
  input  logic [7:0]  iB,
  output logic        oWrReq,
  input  logic        iWrAck,
  output logic [31:0] oWrAddress,
  output logic [63:0] orData,
  output logic [63:0] ogData,
  output logic [63:0] obData,
  output logic [31:0] oPixelCnt,
  output logic        oOverflow,
  output logic        oDone
);
  localparam logic [31:0] LAST_PIX = 32'(width * height - 1);
  localparam logic [31:0] LAST_WORD = 32'(width * height / PIX_PER_WORD - 1);
  logic [2:0] lane_q, lane_d;
  logic [PLANE_WORD_W-1:0] r_acc_q, r_acc_d, g_acc_q, g_acc_d, b_acc_q, b_acc_d;
  logic [31:0] word_idx_q, word_idx_d, pix_cnt_q, pix_cnt_d;
  logic overflow_q, overflow_d, done_q, done_d;
  logic push, pop, drop, full, empty;
  logic [FIFO_ENTRY_W-1:0] fifo_dout;
  entry_t push_entry, head;
  always_comb begin
    r_acc_d = r_acc_q;
    g_acc_d = g_acc_q;
    b_acc_d = b_acc_q;
    if (iValid) begin
      r_acc_d[{lane_q, 3'b000} +: 8] = iR;
      g_acc_d[{lane_q, 3'b000} +: 8] = iG;
      b_acc_d[{lane_q, 3'b000} +: 8] = iB;
    end
    push = iValid && lane_q == 3'd7;
    push_entry = {word_idx_q, b_acc_d, g_acc_d, r_acc_d};
    pop = iWrAck && !empty;
    drop = push && full && !pop;
    lane_d = iValid ? lane_q + 3'd1 : lane_q;
    word_idx_d = push ? (word_idx_q == LAST_WORD ? '0 : word_idx_q + 32'd1) : word_idx_q;
    pix_cnt_d = iValid ? (pix_cnt_q == LAST_PIX ? '0 : pix_cnt_q + 32'd1) : pix_cnt_q;
    overflow_d = overflow_q || drop;
    // the word index travels with the entry, so the frame's last word is recognised on transfer or drop
    done_d = (pop && head.addr == LAST_WORD) || (drop && word_idx_q == LAST_WORD);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_q <= '0;
      r_acc_q <= '0;
      g_acc_q <= '0;
      b_acc_q <= '0;
      word_idx_q <= '0;
      pix_cnt_q <= '0;
      overflow_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      lane_q <= lane_d;
      r_acc_q <= r_acc_d;
      g_acc_q <= g_acc_d;
      b_acc_q <= b_acc_d;
      word_idx_q <= word_idx_d;
      pix_cnt_q <= pix_cnt_d;
      overflow_q <= overflow_d;
      done_q <= done_d;
    end
  end
  sync_fifo_sa #(.W(FIFO_ENTRY_W), .DEPTH(fifoDepth)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(push_entry),
    .dout(fifo_dout),
    .full(full),
    .empty(empty)
  );
  assign head = empty ? '0 : fifo_dout;
  assign oWrReq = !empty;
  assign oWrAddress = head.addr;
  assign orData = head.r;
  assign ogData = head.g;
  assign obData = head.b;
  assign oPixelCnt = pix_cnt_q;
  assign oOverflow = overflow_q;
  assign oDone = done_q;
endmodule

// File: tb/tb_rgb_plane_writer.sv
// tb_rgb_plane_writer: scoreboard bench; 8x5 frame (5 words) with a 4-entry FIFO
`timescale 1ns/1ps
module tb_rgb_plane_writer;
  localparam int W = 8, H = 5, DEPTH = 4;
  localparam int NPIX = W * H, NWORDS = NPIX / 8;
  typedef struct {
    logic [31:0] addr;
    logic [63:0] r, g, b;
    int cyc;
  } word_t;
  logic clk = 0, reset = 1, iValid = 0, iWrAck = 0;
  logic [7:0] iR = 0, iG = 0, iB = 0;
  logic oWrReq, oOverflow, oDone;
  logic [31:0] oWrAddress, oPixelCnt;
  logic [63:0] orData, ogData, obData;
  int n_checks = 0, n_pass = 0, cyc = 0;
  word_t obs_q[$], exp_q[$];
  int done_q[$];
  logic [63:0] m_r, m_g, m_b;
  int m_lane, m_idx;

  rgb_plane_writer #(.width(W), .height(H), .fifoDepth(DEPTH)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iR(iR), .iG(iG), .iB(iB),
    .oWrReq(oWrReq), .iWrAck(iWrAck), .oWrAddress(oWrAddress),
    .orData(orData), .ogData(ogData), .obData(obData),
    .oPixelCnt(oPixelCnt), .oOverflow(oOverflow), .oDone(oDone)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oWrReq && iWrAck) obs_q.push_back('{oWrAddress, orData, ogData, obData, cyc});
    if (oDone) done_q.push_back(cyc);
    cyc <= cyc + 1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1; iValid = 0; iWrAck = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    obs_q.delete(); exp_q.delete(); done_q.delete();
    m_r = 0; m_g = 0; m_b = 0; m_lane = 0; m_idx = 0;
  endtask

  task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int gap, input logic ack);
    @(negedge clk);
    iValid = 1; iR = r; iG = g; iB = b; iWrAck = ack;
    @(posedge clk); #1;
    m_r[8*m_lane +: 8] = r;
    m_g[8*m_lane +: 8] = g;
    m_b[8*m_lane +: 8] = b;
    if (m_lane == 7) begin
      exp_q.push_back('{32'(m_idx), m_r, m_g, m_b, cyc - 1});
      m_idx = (m_idx == NWORDS - 1) ? 0 : m_idx + 1;
    end
    m_lane = (m_lane + 1) % 8;
    repeat (gap) begin @(negedge clk); iValid = 0; end
  endtask

  task automatic idle(input int n, input logic ack);
    repeat (n) begin
      @(negedge clk); iValid = 0; iWrAck = ack;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({oWrReq, oOverflow, oDone} !== 3'b000) $display("FAIL reset_flags: got req/ovf/done=%b exp 000", {oWrReq, oOverflow, oDone}); else n_pass++;
    n_checks++;
    if (oWrAddress !== 0 || oPixelCnt !== 0) $display("FAIL reset_counts: got addr=%0d pixcnt=%0d exp 0/0", oWrAddress, oPixelCnt); else n_pass++;
    n_checks++;
    if ({orData, ogData, obData} !== '0) $display("FAIL reset_data: got r=%h g=%h b=%h exp 0", orData, ogData, obData); else n_pass++;
  endtask

  task automatic test_basic();
    word_t e, o;
    int last_cyc = -100;
    do_reset();
    for (int i = 0; i < NPIX; i++) begin
      send_pixel(8'(i), 8'(i + 64), 8'(255 - i), 0, 1'b1);
      if (i == 9) begin
        n_checks++;
        if (oPixelCnt !== 32'd10) $display("FAIL basic_pixcnt: got %0d exp 10", oPixelCnt); else n_pass++;
      end
    end
    idle(6, 1'b1);
    n_checks++;
    if (obs_q.size() != NWORDS) $display("FAIL basic_count: got %0d words exp %0d", obs_q.size(), NWORDS); else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].addr !== 0 || obs_q[0].r !== 64'h0706050403020100 || obs_q[0].g !== 64'h4746454443424140 || obs_q[0].b !== 64'hF8F9FAFBFCFDFEFF)
      $display("FAIL basic_word0: got r=%h g=%h b=%h exp 0706050403020100/4746454443424140/F8F9FAFBFCFDFEFF", orData, ogData, obData);
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.addr, o.r, o.g, o.b} !== {e.addr, e.r, e.g, e.b}) $display("FAIL basic_word: got addr=%0d r=%h exp addr=%0d r=%h", o.addr, o.r, e.addr, e.r); else n_pass++;
      n_checks++;
      if (o.cyc !== e.cyc + 1) $display("FAIL basic_latency: got transfer cycle %0d exp %0d", o.cyc, e.cyc + 1); else n_pass++;
      if (o.addr == NWORDS - 1) last_cyc = o.cyc;
    end
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != last_cyc + 1) $display("FAIL basic_done: got %0d pulses first at %0d exp 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, last_cyc + 1); else n_pass++;
  endtask

  task automatic test_overflow();
    word_t e, o;
    int drop_edge;
    do_reset();
    for (int i = 0; i < NPIX; i++) send_pixel(8'(i), 8'(i + 64), 8'(255 - i), 0, 1'b0);
    drop_edge = exp_q[$].cyc;
    void'(exp_q.pop_back());
    idle(10, 1'b0);
    n_checks++;
    if (oOverflow !== 1'b1) $display("FAIL ovf_flag: got %b exp 1", oOverflow); else n_pass++;
    n_checks++;
    if (oWrReq !== 1'b1 || oWrAddress !== 0 || orData !== 64'h0706050403020100) $display("FAIL ovf_head: got req=%b addr=%0d r=%h exp 1/0/0706050403020100", oWrReq, oWrAddress, orData); else n_pass++;
    n_checks++;
    if (done_q.size() != 1 || done_q[0] != drop_edge + 1) $display("FAIL ovf_done: got %0d pulses first at %0d exp 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, drop_edge + 1); else n_pass++;
    idle(10, 1'b1);
    n_checks++;
    if (obs_q.size() != 4) $display("FAIL ovf_count: got %0d words exp 4", obs_q.size()); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.addr, o.r, o.g, o.b} !== {e.addr, e.r, e.g, e.b}) $display("FAIL ovf_word: got addr=%0d r=%h exp addr=%0d r=%h", o.addr, o.r, e.addr, e.r); else n_pass++;
    end
    n_checks++;
    if (oOverflow !== 1'b1 || done_q.size() != 1) $display("FAIL ovf_sticky: got ovf=%b done pulses=%0d exp 1/1", oOverflow, done_q.size()); else n_pass++;
  endtask

  task automatic test_gapped();
    word_t e, o;
    do_reset();
    for (int i = 0; i < NPIX; i++) send_pixel(8'(i), 8'(i + 64), 8'(255 - i), 2, 1'b1);
    idle(6, 1'b1);
    n_checks++;
    if (obs_q.size() != NWORDS) $display("FAIL gap_count: got %0d words exp %0d", obs_q.size(), NWORDS); else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].addr !== 0 || obs_q[0].r !== 64'h0706050403020100 || obs_q[0].g !== 64'h4746454443424140 || obs_q[0].b !== 64'hF8F9FAFBFCFDFEFF)
      $display("FAIL gap_word0: got first word differing from 0706050403020100/4746454443424140/F8F9FAFBFCFDFEFF (words seen %0d)", obs_q.size());
    else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.addr, o.r, o.g, o.b} !== {e.addr, e.r, e.g, e.b}) $display("FAIL gap_word: got addr=%0d r=%h exp addr=%0d r=%h", o.addr, o.r, e.addr, e.r); else n_pass++;
    end
    n_checks++;
    if (done_q.size() != 1) $display("FAIL gap_done: got %0d pulses exp 1", done_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    for (int i = 0; i < 5; i++) send_pixel(8'(i + 1), 8'(i + 1), 8'(i + 1), 0, 1'b1);
    n_checks++;
    if (oWrReq !== 1'b0 || obs_q.size() != 0) $display("FAIL midrst_noreq: got req=%b words=%0d exp 0/0", oWrReq, obs_q.size()); else n_pass++;
    do_reset();
    for (int i = 0; i < 8; i++) send_pixel(8'(8'h10 + i), 8'(8'h10 + i), 8'(8'h10 + i), 0, 1'b1);
    idle(6, 1'b1);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 0 || obs_q[0].r !== 64'h1716151413121110)
      $display("FAIL midrst_word: got %0d words addr=%0d r=%h exp 1 word addr=0 r=1716151413121110", obs_q.size(), (obs_q.size() > 0) ? obs_q[0].addr : 32'hFFFFFFFF, (obs_q.size() > 0) ? obs_q[0].r : 64'h0);
    else n_pass++;
    n_checks++;
    if (oPixelCnt !== 32'd8) $display("FAIL midrst_pixcnt: got %0d exp 8", oPixelCnt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    word_t e, o;
    do_reset();
    for (int i = 0; i < 2 * NPIX; i++) begin
      send_pixel(8'(i), 8'(i + 64), 8'(255 - i), 0, 1'b1);
      if (i == NPIX - 1) begin
        n_checks++;
        if (oPixelCnt !== 0) $display("FAIL b2b_pixcnt_wrap: got %0d exp 0", oPixelCnt); else n_pass++;
      end
    end
    idle(6, 1'b1);
    n_checks++;
    if (obs_q.size() != 2 * NWORDS) $display("FAIL b2b_count: got %0d words exp %0d", obs_q.size(), 2 * NWORDS); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.addr, o.r, o.g, o.b} !== {e.addr, e.r, e.g, e.b}) $display("FAIL b2b_word: got addr=%0d r=%h exp addr=%0d r=%h", o.addr, o.r, e.addr, e.r); else n_pass++;
    end
    n_checks++;
    if (done_q.size() != 2) $display("FAIL b2b_done: got %0d pulses exp 2", done_q.size()); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    word_t e, o;
    do_reset();
    for (int i = 0; i < NPIX; i++) send_pixel(8'(i), 8'(i + 64), 8'(255 - i), 0, (i == NPIX - 1) ? 1'b1 : 1'b0);
    idle(5, 1'b0);
    n_checks++;
    if (obs_q.size() != 1 || obs_q[0].addr !== 0) $display("FAIL pp_first: got %0d words exp 1 at addr 0", obs_q.size()); else n_pass++;
    n_checks++;
    if (oOverflow !== 1'b0 || oWrReq !== 1'b1 || oWrAddress !== 32'd1) $display("FAIL pp_state: got ovf=%b req=%b addr=%0d exp 0/1/1", oOverflow, oWrReq, oWrAddress); else n_pass++;
    idle(10, 1'b1);
    n_checks++;
    if (obs_q.size() != NWORDS) $display("FAIL pp_count: got %0d words exp %0d", obs_q.size(), NWORDS); else n_pass++;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if ({o.addr, o.r, o.g, o.b} !== {e.addr, e.r, e.g, e.b}) $display("FAIL pp_word: got addr=%0d r=%h exp addr=%0d r=%h", o.addr, o.r, e.addr, e.r); else n_pass++;
    end
    n_checks++;
    if (oOverflow !== 1'b0 || done_q.size() != 1) $display("FAIL pp_final: got ovf=%b done pulses=%0d exp 0/1", oOverflow, done_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gapped();
    test_reset_mid_word();
    test_back_to_back();
    test_full_push_pop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/rgb_plane_writer.md
# rgb_plane_writer

Final-stage output writer for the processing pipeline. Consumes the 8-bit-per-channel RGB stream from the ycc2rgb stage (`oFinalR/G/B`, `oValidRGB`) and packs it into three planar 64-bit words, one each for R, G and B, with 8 pixels per word. It buffers the packed words in a small FIFO and drains them to frame memory over a req/ack write port. The planar word format and shared word address match the 64-bit `irData/igData/ibData` read format that the convolution engine consumes, so a written frame can be read back directly.

## Interface
Parameters:
- `width`, 1920, pixels per row
- `height`, 1080, rows per frame; `width*height` must be a multiple of 8
- `fifoDepth`, 16, packed-word FIFO entries; power of 2, at least 2

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `iValid`  in  1  pixel strobe, one pixel per cycle while high
- `iR`, `iG`, `iB`  in  8 each  pixel channels
- `oWrReq`  out  1  word available
- `iWrAck`  in  1  memory accepts the word this cycle
- `oWrAddress`  out  32  word index within the frame, shared by all three planes
- `orData`, `ogData`, `obData`  out  64 each  packed plane words
- `oPixelCnt`  out  32  pixels accepted in the current frame
- `oOverflow`  out  1  sticky flag: a word was dropped
- `oDone`  out  1  one-cycle end-of-frame pulse

## Operation
- Reset: every output is 0; the partial word, lane counter, word index, pixel count and FIFO are cleared.
- Packing:
  - The lane counter runs 0..7.
  - A pixel sampled with `iValid=1` in lane k is written to bits [8k+7:8k] of each plane accumulator. Little-endian: pixel 0 lands in the LSB.
  - In lane 7, the three words plus the current word index are pushed as one 224-bit FIFO entry. The word index then increments.
  - Cycles with `iValid=0` leave all packing state unchanged.
- Word index: runs 0..`width*height/8`-1, then wraps to 0. The index is assigned at pack time, so a dropped word never shifts later addresses.
- `oPixelCnt` increments per accepted pixel and wraps to 0 after `width*height`-1.
- Write handshake:
  - `oWrReq` equals "FIFO not empty". The FIFO is show-ahead, so the head entry drives `oWrAddress` and the data outputs.
  - A transfer occurs on any cycle with `oWrReq && iWrAck`. The head is popped on that edge.
  - `iWrAck` while `oWrReq=0` is ignored.
  - Data and address outputs stay stable while `oWrReq=1` and no ack has been given. They are 0 while the FIFO is empty.
- Overflow:
  - A push into a full FIFO with no pop on the same cycle drops the word and sets `oOverflow`. The flag holds until reset.
  - A push and pop on the same cycle with the FIFO full is legal: no drop, occupancy unchanged.
- Done: `oDone` pulses when the word with index `width*height/8`-1 is either transferred or dropped.
- Frame boundaries: pixels arriving before the previous frame drains belong to the next frame and are packed normally. No stall, no bubble.
- Reset mid-operation: the partial word and FIFO contents are discarded and no request is issued for them.

## Timing
- The 8th pixel of a word is sampled at edge N. The FIFO push happens at edge N, and `oWrReq`/data are valid from edge N+1.
- With `iWrAck` tied to 1, a continuous stream gives one word every 8 cycles with latency 1.
- `oDone` is registered: it is high for the single cycle after the qualifying transfer or drop edge.
- Throughput: 1 pixel/cycle sustained, provided memory acks at least 1 in 8 cycles on average.
- FIFO occupancy counter: 0..`fifoDepth`, with simultaneous push/pop handled as described above.

## Structure
- Shared params package holds: `PIX_PER_WORD`=8, `PLANE_WORD_W`=64, `FIFO_ENTRY_W`=224 (3×64 data + 32 address).
- One sub-module: `sync_fifo_sa`, a parameterised single-clock show-ahead FIFO (width, depth) with `full`/`empty` outputs. The top holds the accumulator, counters, overflow and done logic.
- Target size: about 200 RTL lines.

## Test plan
- Basic frame: `width`=16, `height`=2, `iWrAck`=1, pixel i with R=i, G=i+64, B=255−i. Expect 4 words at addresses 0..3. Word 0 `orData`=0x0706050403020100, `ogData`=0x4746454443424140, `obData`=0xF8F9FAFBFCFDFEFF. `oDone` pulses once, one cycle after the address-3 transfer.
- Backpressure with overflow: `fifoDepth`=4, `iWrAck`=0 for 50 cycles while 40 pixels arrive.
  - Expect the word at address 4 to be dropped and `oOverflow`=1.
  - After ack resumes, addresses 0..3 transfer in order.
  - `oDone` pulses on the address-4 drop when the frame has 5 words.
- Gapped input: `iValid` high every 3rd cycle. Expect word contents and addresses identical to the basic-frame test.
- Reset mid-word: 5 pixels, then reset, then 8 pixels of values 0x10..0x17. Expect no request before reset. Exactly one word follows: address 0, `orData`=0x1716151413121110.
- Back-to-back frames: two 32-pixel frames with no gap. Expect addresses 0..3 then 0..3 again, `oDone` pulsing twice, and `oPixelCnt` returning to 0 after pixel 31.
- Full FIFO with simultaneous push and pop: fill the FIFO, then assert `iWrAck` on the cycle a new word completes. Expect no drop, `oOverflow`=0, and occupancy unchanged.
